ovf_event_monitor: RTL and testbench
====================================

Name: ovf_event_monitor

Overview:
Downstream consumer of the 8-bit overflow counter's `overflow` output. Counts rising edges of `overflow` over fixed measurement windows of enabled clock cycles. At each window close it snapshots the edge count into a report register offered on a valid/ready interface. It also raises a threshold alarm when a window's count reaches a programmable limit.

Parameters:
CNT_W, 8, width of event count, threshold and report data
WINDOW, 256, number of enabled (`en`=1) cycles per measurement window; legal range 2..65535

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  enable; window timer and event counting advance only when 1
overflow  input  1  level from upstream counter; each 0->1 transition is one event
thresh  input  CNT_W  alarm threshold, sampled at window close; 0 disables the alarm
rpt_ready  input  1  consumer accepts the report when rpt_valid and rpt_ready are both 1
rpt_valid  output  1  report register holds an unaccepted snapshot
rpt_count  output  CNT_W  event count of the reported window
rpt_sat  output  1  event count saturated during the reported window
rpt_drop  output  1  one-cycle pulse: window closed while the previous report was still pending; new snapshot discarded
alarm  output  1  registered; set at window close when snapshot >= thresh and thresh != 0, otherwise cleared at window close

Behaviour:
- Reset (async assert, sync-safe release): ovf_q=0, timer=0, evt_cnt=0, sat=0, rpt_valid=0, rpt_count=0, rpt_sat=0, rpt_drop=0, alarm=0, run state=IDLE, report state=EMPTY.
- Edge detect: ovf_q <= overflow every cycle, regardless of `en`. Event = overflow & ~ovf_q.
  - A level held high counts once.
  - A rise while en=0 is never counted later.
- Run FSM:
  - IDLE -> RUN when en=1.
  - RUN -> IDLE when en=0.
  - In IDLE, timer, evt_cnt and sat hold; events are ignored.
- In RUN, each cycle:
  - If event: evt_cnt+1, saturating at 2^CNT_W-1. An event arriving at saturation sets sat.
  - timer increments. At timer==WINDOW-1 the window closes.
- Window close (same cycle):
  - Snapshot value = evt_cnt plus that cycle's event (saturating); snapshot sat includes that cycle.
  - timer<=0, evt_cnt<=0, sat<=0.
  - alarm is updated from the snapshot and the current `thresh`.
- Report FSM (EMPTY/FULL):
  - EMPTY + close: load rpt_count/rpt_sat, go to FULL. rpt_valid=1 on the next cycle, i.e. latency 1 cycle after the closing cycle.
  - FULL: rpt_count/rpt_sat stay stable until a handshake. Handshake without close -> EMPTY, rpt_valid=0 next cycle.
  - FULL + handshake + close in the same cycle: accept the old report, load the new one, stay FULL, rpt_valid stays 1.
  - FULL + close without handshake: new snapshot dropped, rpt_drop=1 for one cycle. alarm is still updated from the dropped snapshot.
- rpt_ready while rpt_valid=0 has no effect.
- Reset mid-window or mid-report discards all state, including a pending report.

Decomposition:
- Package ovf_mon_pkg:
  - run_state_t {IDLE, RUN}
  - rpt_state_t {EMPTY, FULL}
  - localparam DEF_CNT_W=8, DEF_WINDOW=256
  - function sat_inc(val, inc), returning a saturating sum plus a saturation flag.
- One sub-module, rise_detect: clk, rst_n, d, rise; holds the ovf_q register. Everything else lives in the top module.

Test Plan (bench uses WINDOW=8, CNT_W=4; clk period 10 ns; rst_n low for 2 cycles):
1. en=1; overflow pulsed high 1 cycle on cycles 1, 3, 5; rpt_ready=1 -> rpt_valid=1 one cycle after window close, rpt_count=3, rpt_sat=0, rpt_drop=0; thresh=3 gives alarm=1, thresh=4 gives alarm=0.
2. overflow held high 6 cycles inside one window -> rpt_count=1. Then 20 single-cycle pulses across windows spaced so 17 fall in one window (WINDOW raised to 40 for this case) -> rpt_count=15, rpt_sat=1.
3. en dropped for 5 cycles mid-window with 2 overflow rises during that gap -> those rises not counted; window closes 5 cycles later than without the gap; rpt_count excludes them.
4. rpt_ready=0 across two window closes -> first report stays stable and rpt_valid stays high; rpt_drop=1 for exactly one cycle at the second close. Raising rpt_ready in the same cycle as a third close -> rpt_valid stays 1 and rpt_count shows the third window's value.
5. Event on the exact closing cycle -> included in that window's rpt_count; the next window starts at 0.
6. rst_n asserted asynchronously (mid-cycle) while FULL with evt_cnt=2 -> rpt_valid, alarm and rpt_count go to 0 immediately; after release the first report covers only post-reset events.

Source files
------------

// File: rtl/ovf_mon_pkg.sv
// Shared types and helpers for the overflow event monitor.
package ovf_mon_pkg;

  typedef enum logic {IDLE, RUN} run_state_t;
  typedef enum logic {EMPTY, FULL} rpt_state_t;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_WINDOW = 256;

  typedef struct packed {
    logic [31:0] sum;
    logic        sat;
  } sat_res_t;

  // sat flags an increment that arrived while val was already at maxVal
  function automatic sat_res_t sat_inc(input logic [31:0] val, input logic inc,
                                       input logic [31:0] maxVal);
    sat_res_t r;
    r.sum = val;
    r.sat = 1'b0;
    if (inc) begin
      if (val >= maxVal) r.sat = 1'b1;
      else               r.sum = val + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ovf_event_monitor_rise_detect.sv
// Rising-edge detector for the upstream overflow level; samples every cycle.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= d;
  end

  assign rise = d & ~ovf_q;

endmodule

// File: rtl/ovf_event_monitor.sv
// Counts overflow rising edges per window of enabled cycles and offers a
// one-deep report register plus a threshold alarm at every window close.
module ovf_event_monitor
  import ovf_mon_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             overflow,
  input  logic [CNT_W-1:0] thresh,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_sat,
  output logic             rpt_drop,
  output logic             alarm
);

  localparam logic [31:0] CNT_MAX   = (32'd1 << CNT_W) - 32'd1;
  localparam logic [15:0] LAST_TICK = 16'(WINDOW - 1);

  logic             evt;
  run_state_t       runState;
  logic [15:0]      timer_q, timer_d;
  logic [CNT_W-1:0] evtCnt_q, evtCnt_d;
  logic             sat_q, sat_d;
  sat_res_t         incRes;
  logic [CNT_W-1:0] snapCnt;
  logic             snapSat;
  logic             closeNow;
  logic             handshake;

  rpt_state_t       rptState_q;
  logic [CNT_W-1:0] rptCount_q;
  logic             rptSat_q;
  logic             rptDrop_q;
  logic             alarm_q;

  rise_detect uRise (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (overflow),
    .rise (evt)
  );

  // Run mode follows en directly, so a paused window resumes with no lost or extra cycles.
  assign runState = en ? RUN : IDLE;

  always_comb begin
    incRes   = sat_inc(32'(evtCnt_q), evt, CNT_MAX);
    snapCnt  = CNT_W'(incRes);
    snapCnt  = CNT_W'(incRes.sum);
    snapSat  = sat_q | incRes.sat;
    closeNow = (runState == RUN) && (timer_q == LAST_TICK);
    timer_d  = timer_q;
    evtCnt_d = evtCnt_q;
    sat_d    = sat_q;
    if (runState == RUN) begin
      if (closeNow) begin
        timer_d  = '0;
        evtCnt_d = '0;
        sat_d    = 1'b0;
      end else begin
        timer_d  = timer_q + 16'd1;
        evtCnt_d = snapCnt;
        sat_d    = snapSat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= '0;
      evtCnt_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      evtCnt_q <= evtCnt_d;
      sat_q    <= sat_d;
    end
  end

  assign handshake = (rptState_q == FULL) && rpt_ready;

  // A close during a handshake refills the register in the same cycle; otherwise a busy register drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptState_q <= EMPTY;
      rptCount_q <= '0;
      rptSat_q   <= 1'b0;
      rptDrop_q  <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      rptDrop_q <= 1'b0;
      if (closeNow) begin
        alarm_q <= (thresh != '0) && (snapCnt >= thresh);
        if ((rptState_q == EMPTY) || handshake) begin
          rptCount_q <= snapCnt;
          rptSat_q   <= snapSat;
          rptState_q <= FULL;
        end else begin
          rptDrop_q <= 1'b1;
        end
      end else if (handshake) begin
        rptState_q <= EMPTY;
      end
    end
  end

  assign rpt_valid = (rptState_q == FULL);
  assign rpt_count = rptCount_q;
  assign rpt_sat   = rptSat_q;
  assign rpt_drop  = rptDrop_q;
  assign alarm     = alarm_q;

endmodule

// File: tb/tb_ovf_event_monitor.sv
// Scoreboard bench: two monitors (window 8 and 40) share one stimulus stream and
// are checked against a window-level reference model.
module tb_ovf_event_monitor;

  localparam int CW   = 4;
  localparam int MAXC = 15;
  localparam int WIN0 = 8;
  localparam int WIN1 = 40;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          overflow;
  logic          rpt_ready;
  logic [CW-1:0] thresh;
  logic [1:0]    rptValid;
  logic [1:0]    rptSat;
  logic [1:0]    rptDrop;
  logic [1:0]    alarm;
  logic [CW-1:0] rptCount [2];

  typedef struct {
    int inst;
    int cnt;
    bit sat;
  } rep_t;

  rep_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   mEnCycles[2];
  int   mRises[2];
  int   mCloses[2];
  bit   mPend[2];
  bit   mAlarm[2];
  bit   mDrop[2];
  bit   prevOvf;
  bit   chkOn;

  always #5 clk = ~clk;

  ovf_event_monitor #(.CNT_W(CW), .WINDOW(WIN0)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .overflow(overflow), .thresh(thresh),
    .rpt_ready(rpt_ready), .rpt_valid(rptValid[0]), .rpt_count(rptCount[0]),
    .rpt_sat(rptSat[0]), .rpt_drop(rptDrop[0]), .alarm(alarm[0])
  );

  ovf_event_monitor #(.CNT_W(CW), .WINDOW(WIN1)) dut40 (
    .clk(clk), .rst_n(rst_n), .en(en), .overflow(overflow), .thresh(thresh),
    .rpt_ready(rpt_ready), .rpt_valid(rptValid[1]), .rpt_count(rptCount[1]),
    .rpt_sat(rptSat[1]), .rpt_drop(rptDrop[1]), .alarm(alarm[1])
  );

  task automatic checkOutput(string name, int inst, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: got %0d expected %0d at %0t", name, inst, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mEnCycles[i] = 0;
      mRises[i]    = 0;
      mPend[i]     = 1'b0;
      mAlarm[i]    = 1'b0;
      mDrop[i]     = 1'b0;
    end
    sbq.delete();
    prevOvf = 1'b0;
  endtask

  // One clock edge of the reference: rises are tallied per window of enabled
  // cycles and clipped to the counter range only when the window is reported.
  task automatic modelStep();
    bit   rise;
    bit   hs;
    bit   closed;
    int   cnt;
    int   winLen;
    rep_t r;
    rise    = overflow && !prevOvf;
    prevOvf = overflow;
    for (int i = 0; i < 2; i++) begin
      winLen   = (i == 0) ? WIN0 : WIN1;
      mDrop[i] = 1'b0;
      closed   = 1'b0;
      hs       = mPend[i] && rpt_ready;
      if (en) begin
        if (rise) mRises[i]++;
        mEnCycles[i]++;
        if (mEnCycles[i] == winLen) begin
          cnt       = (mRises[i] > MAXC) ? MAXC : mRises[i];
          mAlarm[i] = (thresh != 0) && (cnt >= int'(thresh));
          if (!mPend[i] || hs) begin
            r.inst = i;
            r.cnt  = cnt;
            r.sat  = (mRises[i] > MAXC);
            sbq.push_back(r);
            mPend[i] = 1'b1;
          end else begin
            mDrop[i] = 1'b1;
          end
          mEnCycles[i] = 0;
          mRises[i]    = 0;
          mCloses[i]++;
          closed = 1'b1;
        end
      end
      if (hs && !closed) mPend[i] = 1'b0;
    end
  endtask

  task automatic applyStimulus(bit e, bit o, bit r, int th);
    @(posedge clk);
    modelStep();
    #1;
    en        = e;
    overflow  = o;
    rpt_ready = r;
    thresh    = CW'(th);
  endtask

  task automatic midCycleReset();
    #3;
    chkOn = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput("async_rst_valid", i, rptValid[i], 0);
      checkOutput("async_rst_alarm", i, alarm[i], 0);
      checkOutput("async_rst_count", i, rptCount[i], 0);
    end
    modelReset();
    overflow  = 1'b0;
    rpt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    chkOn = 1'b1;
  endtask

  // Monitor: every DUT output is compared against the model each cycle, and a
  // presented report is compared against the oldest expected report for that unit.
  always @(negedge clk) begin
    int idx;
    if (chkOn) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput("rpt_valid", i, rptValid[i], mPend[i]);
        checkOutput("rpt_drop", i, rptDrop[i], mDrop[i]);
        checkOutput("alarm", i, alarm[i], mAlarm[i]);
        if (rptValid[i]) begin
          idx = -1;
          for (int k = 0; k < sbq.size(); k++) begin
            if (sbq[k].inst == i) begin
              idx = k;
              break;
            end
          end
          if (idx < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_empty dut%0d: got report count %0d expected no report at %0t", i, rptCount[i], $time);
          end else begin
            checkOutput("rpt_count", i, rptCount[i], sbq[idx].cnt);
            checkOutput("rpt_sat", i, rptSat[i], sbq[idx].sat);
            if (rpt_ready) sbq.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    int guard;
    int base;
    int left;
    bit tog;
    rst_n     = 1'b0;
    en        = 1'b0;
    overflow  = 1'b0;
    rpt_ready = 1'b0;
    thresh    = '0;
    chkOn     = 1'b0;
    mCloses[0] = 0;
    mCloses[1] = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset_valid", i, rptValid[i], 0);
      checkOutput("reset_count", i, rptCount[i], 0);
      checkOutput("reset_sat", i, rptSat[i], 0);
      checkOutput("reset_drop", i, rptDrop[i], 0);
      checkOutput("reset_alarm", i, alarm[i], 0);
    end
    rst_n = 1'b1;
    chkOn = 1'b1;

    $display("[TB] basic window: pulses on cycles 1,3,5, thresh 3 then 4");
    for (int c = 0; c < 16; c++)
      applyStimulus(1'b1, ((c % 8) == 1) || ((c % 8) == 3) || ((c % 8) == 5), 1'b1, (c < 8) ? 3 : 4);

    $display("[TB] held level, then 20 pulses with 17 in one long window");
    for (int c = 0; c < 8; c++)
      applyStimulus(1'b1, (c >= 1) && (c < 7), 1'b1, 1);
    for (int c = 0; c < 56; c++)
      applyStimulus(1'b1, (c >= 11) && (c <= 49) && (((c - 11) % 2) == 0), 1'b1, 8);

    $display("[TB] enable gap with rises inside it");
    for (int c = 0; c < 14; c++)
      applyStimulus(!((c >= 4) && (c < 9)), (c == 5) || (c == 7) || (c == 11), 1'b1, 2);

    $display("[TB] backpressure across two closes, ready on the third");
    base  = mCloses[0];
    guard = 0;
    while ((mCloses[0] < base + 2) && (guard < 100)) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 2);
      guard++;
    end
    while ((mEnCycles[0] != WIN0 - 2) && (guard < 200)) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 2);
      guard++;
    end
    applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1, 2);
    for (int c = 0; c < 4; c++)
      applyStimulus(1'b1, 1'b0, 1'b1, 2);

    $display("[TB] event on the closing cycle");
    guard = 0;
    while ((mEnCycles[0] != WIN0 - 2) && (guard < 50)) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1);
      guard++;
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    for (int c = 0; c < 10; c++)
      applyStimulus(1'b1, 1'b0, 1'b1, 1);

    $display("[TB] asynchronous reset with a pending report");
    guard = 0;
    tog   = 1'b0;
    while (!(mPend[0] && (mRises[0] == 2)) && (guard < 200)) begin
      tog = !tog;
      applyStimulus(1'b1, tog, 1'b0, 1);
      guard++;
    end
    checkOutput("pend_before_reset", 0, rptValid[0], 1);
    midCycleReset();
    for (int c = 0; c < 20; c++)
      applyStimulus(1'b1, (c % 3) == 0, 1'b1, 3);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 1500; c++)
      applyStimulus($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)));

    for (int c = 0; c < 4; c++)
      applyStimulus(1'b0, 1'b0, 1'b1, 0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      left = 0;
      foreach (sbq[k]) if (sbq[k].inst == i) left++;
      checkOutput("sb_leftover", i, left, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
